// File: rtl/nor_vector_checker.sv
// On-chip checker for a NOR gate under test: compares each observed F against ~(A | B),
// counts vectors and mismatches, and captures the first failing vector of a run.
module nor_vector_checker #(
    parameter int N            = 4,
    parameter int NUM_VEC      = 3,
    parameter int STOP_ON_FAIL = 1,
    parameter int CNT_W        = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N-1:0]     A,
    input  logic [N-1:0]     B,
    input  logic [N-1:0]     F,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] vec_count,
    output logic [CNT_W-1:0] err_count,
    output logic [CNT_W-1:0] first_fail_idx,
    output logic [N-1:0]     first_fail_exp,
    output logic [N-1:0]     first_fail_got
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t         state;
    state_t         next_state;
    logic           clear;
    logic           accept;
    logic           mismatch;
    logic           last_vec;
    logic [N-1:0]   exp_f;

    assign exp_f    = ~(A | B);
    assign accept   = in_valid && (state == RUN);
    assign mismatch = (F != exp_f);
    assign last_vec = (vec_count == CNT_W'(NUM_VEC - 1));

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    // start is only honoured outside RUN; leaving IDLE/DONE also wipes the previous run's results
    always_comb begin
        next_state = state;
        clear      = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    next_state = RUN;
                    clear      = 1'b1;
                end
            end
            RUN: begin
                if (accept && (last_vec || ((STOP_ON_FAIL != 0) && mismatch)))
                    next_state = DONE;
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            vec_count      <= '0;
            err_count      <= '0;
            first_fail_idx <= '0;
            first_fail_exp <= '0;
            first_fail_got <= '0;
        end else if (accept) begin
            vec_count <= vec_count + CNT_W'(1);
            if (mismatch) begin
                if (err_count != '1)
                    err_count <= err_count + CNT_W'(1);
                // Only the very first mismatch of a run is captured
                if (err_count == '0) begin
                    first_fail_idx <= vec_count;
                    first_fail_exp <= exp_f;
                    first_fail_got <= F;
                end
            end
        end
    end

    assign in_ready = (state == RUN);
    assign busy     = (state == RUN);
    assign done     = (state == DONE);
    assign pass     = (state == DONE) && (err_count == '0);

endmodule

// File: tb/tb_nor_vector_checker.sv
// Scoreboard bench: two checkers (stop-on-fail and run-all) share one stimulus stream;
// expected run results are queued at issue time and popped when each checker reports done.
module tb_nor_vector_checker;

    localparam int N       = 4;
    localparam int NUM_VEC = 3;
    localparam int CNT_W   = 8;

    typedef struct {
        int vc;
        int ec;
        int idx;
        int fexp;
        int fgot;
        int pass;
    } result_t;

    logic clk = 1'b0;
    logic rst, start, in_valid;
    logic [N-1:0] A, B, F;

    logic rdy_s, busy_s, done_s, pass_s;
    logic [CNT_W-1:0] vc_s, ec_s, idx_s;
    logic [N-1:0] fexp_s, fgot_s;
    logic rdy_a, busy_a, done_a, pass_a;
    logic [CNT_W-1:0] vc_a, ec_a, idx_a;
    logic [N-1:0] fexp_a, fgot_a;

    int checks = 0;
    int errors = 0;
    result_t q_s[$];
    result_t q_a[$];
    logic [N-1:0] va[NUM_VEC];
    logic [N-1:0] vb[NUM_VEC];
    logic [N-1:0] vf[NUM_VEC];
    logic prev_done_s = 1'b0;
    logic prev_done_a = 1'b0;

    always #5 clk = ~clk;

    nor_vector_checker #(.N(N), .NUM_VEC(NUM_VEC), .STOP_ON_FAIL(1), .CNT_W(CNT_W)) dut_stop (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(rdy_s),
        .A(A), .B(B), .F(F), .busy(busy_s), .done(done_s), .pass(pass_s),
        .vec_count(vc_s), .err_count(ec_s), .first_fail_idx(idx_s),
        .first_fail_exp(fexp_s), .first_fail_got(fgot_s)
    );

    nor_vector_checker #(.N(N), .NUM_VEC(NUM_VEC), .STOP_ON_FAIL(0), .CNT_W(CNT_W)) dut_all (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(rdy_a),
        .A(A), .B(B), .F(F), .busy(busy_a), .done(done_a), .pass(pass_a),
        .vec_count(vc_a), .err_count(ec_a), .first_fail_idx(idx_a),
        .first_fail_exp(fexp_a), .first_fail_got(fgot_a)
    );

    task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] expv);
        checks++;
        if (got !== expv) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, got, expv);
        end
    endtask

    // Run result derived directly from the rules: NOR each vector, stop early only in stop mode
    function automatic result_t model(input bit stop);
        result_t r;
        logic [N-1:0] e;
        r = '{default: 0};
        for (int i = 0; i < NUM_VEC; i++) begin
            e = ~(va[i] | vb[i]);
            r.vc++;
            if (vf[i] !== e) begin
                if (r.ec == 0) begin
                    r.idx  = i;
                    r.fexp = int'(e);
                    r.fgot = int'(vf[i]);
                end
                if (r.ec < (2 ** CNT_W) - 1) r.ec++;
                if (stop) break;
            end
        end
        r.pass = (r.ec == 0) ? 1 : 0;
        return r;
    endfunction

    task automatic compareResult(input string tag, input result_t r,
                                 input logic [CNT_W-1:0] vc, input logic [CNT_W-1:0] ec,
                                 input logic [CNT_W-1:0] idx, input logic [N-1:0] fexp,
                                 input logic [N-1:0] fgot, input logic ps,
                                 input logic rdy, input logic bsy);
        checkOutput({tag, "_vec_count"}, 32'(vc), r.vc);
        checkOutput({tag, "_err_count"}, 32'(ec), r.ec);
        checkOutput({tag, "_first_fail_idx"}, 32'(idx), r.idx);
        checkOutput({tag, "_first_fail_exp"}, 32'(fexp), r.fexp);
        checkOutput({tag, "_first_fail_got"}, 32'(fgot), r.fgot);
        checkOutput({tag, "_pass"}, 32'(ps), r.pass);
        checkOutput({tag, "_in_ready_done"}, 32'(rdy), 0);
        checkOutput({tag, "_busy_done"}, 32'(bsy), 0);
    endtask

    always @(negedge clk) begin
        if (done_s && !prev_done_s) begin
            if (q_s.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_done_stop: got done=1 expected no result pending");
            end else begin
                compareResult("stop", q_s.pop_front(), vc_s, ec_s, idx_s, fexp_s, fgot_s,
                              pass_s, rdy_s, busy_s);
            end
        end
        prev_done_s <= done_s;
    end

    always @(negedge clk) begin
        if (done_a && !prev_done_a) begin
            if (q_a.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_done_all: got done=1 expected no result pending");
            end else begin
                compareResult("all", q_a.pop_front(), vc_a, ec_a, idx_a, fexp_a, fgot_a,
                              pass_a, rdy_a, busy_a);
            end
        end
        prev_done_a <= done_a;
    end

    task automatic checkCleared(input string tag);
        checkOutput({tag, "_rdy_s"}, 32'(rdy_s), 0);
        checkOutput({tag, "_busy_s"}, 32'(busy_s), 0);
        checkOutput({tag, "_done_s"}, 32'(done_s), 0);
        checkOutput({tag, "_pass_s"}, 32'(pass_s), 0);
        checkOutput({tag, "_vc_s"}, 32'(vc_s), 0);
        checkOutput({tag, "_ec_s"}, 32'(ec_s), 0);
        checkOutput({tag, "_idx_s"}, 32'(idx_s), 0);
        checkOutput({tag, "_fexp_s"}, 32'(fexp_s), 0);
        checkOutput({tag, "_fgot_s"}, 32'(fgot_s), 0);
        checkOutput({tag, "_rdy_a"}, 32'(rdy_a), 0);
        checkOutput({tag, "_done_a"}, 32'(done_a), 0);
        checkOutput({tag, "_vc_a"}, 32'(vc_a), 0);
        checkOutput({tag, "_ec_a"}, 32'(ec_a), 0);
    endtask

    // gap_mode: 0 = back-to-back, 1 = valid pattern 1,0,0,1,0,1, 2 = random gaps
    task automatic applyStimulus(input int gap_mode, input bit stray);
        int gaps;
        q_s.push_back(model(1'b1));
        q_a.push_back(model(1'b0));
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        checkOutput("run_busy_s", 32'(busy_s), 1);
        checkOutput("run_done_s", 32'(done_s), 0);
        checkOutput("run_pass_s", 32'(pass_s), 0);
        checkOutput("run_vc_s", 32'(vc_s), 0);
        checkOutput("run_ec_s", 32'(ec_s), 0);
        checkOutput("run_rdy_a", 32'(rdy_a), 1);
        checkOutput("run_vc_a", 32'(vc_a), 0);
        checkOutput("run_ec_a", 32'(ec_a), 0);
        for (int i = 0; i < NUM_VEC; i++) begin
            case (gap_mode)
                1:       gaps = (i == 1) ? 2 : ((i == 2) ? 1 : 0);
                2:       gaps = int'($urandom_range(0, 2));
                default: gaps = 0;
            endcase
            for (int g = 0; g < gaps; g++) begin
                in_valid = 1'b0;
                A = N'($urandom);
                B = N'($urandom);
                F = N'($urandom);
                @(posedge clk); #1;
            end
            A = va[i];
            B = vb[i];
            F = vf[i];
            in_valid = 1'b1;
            start = stray && (i == 1 || i == NUM_VEC - 1);
            @(posedge clk); #1;
            in_valid = 1'b0;
            start = 1'b0;
        end
        repeat (3) @(posedge clk);
        #1;
        checkOutput("pending_stop", 32'(q_s.size()), 0);
        checkOutput("pending_all", 32'(q_a.size()), 0);
        q_s.delete();
        q_a.delete();
    endtask

    task automatic setVec(input int i, input logic [N-1:0] a, input logic [N-1:0] b,
                          input logic [N-1:0] f);
        va[i] = a;
        vb[i] = b;
        vf[i] = f;
    endtask

    task automatic loadAllPass();
        setVec(0, 4'b1010, 4'b0000, 4'b0101);
        setVec(1, 4'b1100, 4'b1111, 4'b0000);
        setVec(2, 4'b0000, 4'b1111, 4'b0000);
    endtask

    initial begin
        logic [N-1:0] e, flip;
        rst = 1'b1;
        start = 1'b0;
        in_valid = 1'b0;
        A = '0;
        B = '0;
        F = '0;
        repeat (3) @(posedge clk);
        #1;
        checkCleared("reset");
        rst = 1'b0;

        $display("[TB] all-pass run");
        loadAllPass();
        applyStimulus(0, 1'b0);

        $display("[TB] single mismatch on vector 1");
        loadAllPass();
        setVec(1, 4'b1100, 4'b1111, 4'b0001);
        applyStimulus(0, 1'b0);

        $display("[TB] mismatches on vectors 0 and 2");
        loadAllPass();
        setVec(0, 4'b1010, 4'b0000, 4'b1111);
        setVec(2, 4'b0000, 4'b1111, 4'b1111);
        applyStimulus(0, 1'b0);

        $display("[TB] valid gaps");
        loadAllPass();
        applyStimulus(1, 1'b0);

        $display("[TB] stray start during run");
        loadAllPass();
        applyStimulus(2, 1'b1);

        $display("[TB] reset mid-run");
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        A = 4'b1010;
        B = 4'b0000;
        F = 4'b0101;
        in_valid = 1'b1;
        @(posedge clk); #1;
        checkOutput("midrun_vc_s", 32'(vc_s), 1);
        rst = 1'b1;
        A = 4'b1100;
        B = 4'b1111;
        F = 4'b0000;
        @(posedge clk); #1;
        rst = 1'b0;
        in_valid = 1'b0;
        checkCleared("midrun_reset");
        repeat (2) @(posedge clk);
        #1;
        checkCleared("after_reset");
        loadAllPass();
        applyStimulus(0, 1'b0);

        $display("[TB] random runs");
        for (int r = 0; r < 25; r++) begin
            for (int i = 0; i < NUM_VEC; i++) begin
                va[i] = N'($urandom);
                vb[i] = N'($urandom);
                e = ~(va[i] | vb[i]);
                flip = '0;
                if ($urandom_range(0, 3) == 0) begin
                    flip = N'($urandom);
                    if (flip == '0) flip = N'(1);
                end
                vf[i] = e ^ flip;
            end
            applyStimulus(2, 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
